alu_mul_seq: RTL and testbench

Multi-cycle unsigned multiplier sequencer that borrows the shared 8-bit ALU through a request/grant pair. It runs the shift-and-add algorithm using only the ALU's ADD operation. Each bit takes one granted cycle, and the block returns a double-width product. It sits beside the ALU and the other ALU users, with an external arbiter driving `alu_gnt`.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu.sv | 45 ++++
 rtl/alu_mul_seq.sv | 104 ++++++++++
 tb/tb_alu_mul_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes and the multiply sequencer state type, used by every ALU client
// and the arbiter.
package alu_pkg;

   localparam logic [3:0] ALU_LD   = 4'd0;
   localparam logic [3:0] ALU_AND  = 4'd1;
   localparam logic [3:0] ALU_OR   = 4'd2;
   localparam logic [3:0] ALU_XOR  = 4'd3;
   localparam logic [3:0] ALU_ADD  = 4'd4;
   localparam logic [3:0] ALU_SUB  = 4'd5;
   localparam logic [3:0] ALU_INK  = 4'd6;
   localparam logic [3:0] ALU_NOT  = 4'd7;
   localparam logic [3:0] ALU_ADDC = 4'd8;
   localparam logic [3:0] ALU_SUBC = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU. The top bit of the widened result is the carry, or the
// borrow for the subtract operations.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [3:0]        i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic              i_c_in,
   output logic [DATA_W-1:0] o_out,
   output logic              o_c
);

   logic [DATA_W:0] w_a;
   logic [DATA_W:0] w_b;
   logic [DATA_W:0] w_ci;
   logic [DATA_W:0] w_res;

   assign w_a  = {1'b0, i_a};
   assign w_b  = {1'b0, i_b};
   assign w_ci = {{DATA_W{1'b0}}, i_c_in};

   always_comb begin
      w_res = '0;
      case (i_op)
         ALU_LD:   w_res = w_b;
         ALU_AND:  w_res = w_a & w_b;
         ALU_OR:   w_res = w_a | w_b;
         ALU_XOR:  w_res = w_a ^ w_b;
         ALU_ADD:  w_res = w_a + w_b;
         ALU_SUB:  w_res = w_a - w_b;
         ALU_INK:  w_res = w_a + {{DATA_W{1'b0}}, 1'b1};
         ALU_NOT:  w_res = {1'b0, ~i_a};
         ALU_ADDC: w_res = w_a + w_b + w_ci;
         ALU_SUBC: w_res = w_a - w_b - w_ci;
         default:  w_res = '0;
      endcase
   end

   assign o_out = w_res[DATA_W-1:0];
   assign o_c   = w_res[DATA_W];

endmodule

// File: rtl/alu_mul_seq.sv
// Unsigned shift-and-add multiplier that borrows the shared ALU for one ADD per
// multiplier bit, stalling whenever the arbiter withholds the grant.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     mcand,
   input  logic [DATA_W-1:0]     mplier,
   output logic                  busy,
   output logic                  done,
   output logic [2*DATA_W-1:0]   result,
   output logic                  alu_req,
   input  logic                  alu_gnt,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   output logic [3:0]            alu_op,
   output logic                  alu_c_in,
   input  logic [DATA_W-1:0]     alu_out,
   input  logic                  alu_c
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   seq_state_e r_state;
   seq_state_e w_state_nxt;

   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;
   logic [DATA_W-1:0]   r_mc;
   logic [CNT_W-1:0]    r_cnt;
   logic [2*DATA_W-1:0] r_result;
   logic                r_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_nxt = RUN;
         RUN:     if (alu_gnt && (r_cnt == CNT_LAST)) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (r_state == RUN) || (r_state == DONE);
      alu_req = (r_state == RUN);
      alu_op  = (r_state == RUN) ? ALU_ADD : ALU_LD;
   end

   // Each step shifts the (DATA_W+1)-bit partial sum right by one across hi:lo.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_mc     <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == DONE);
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_hi  <= '0;
                  r_lo  <= mplier;
                  r_mc  <= mcand;
                  r_cnt <= '0;
               end
            end
            RUN: begin
               if (alu_gnt) begin
                  r_hi  <= {alu_c, alu_out[DATA_W-1:1]};
                  r_lo  <= {alu_out[0], r_lo[DATA_W-1:1]};
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_result <= {r_hi, r_lo};
            end
            default: ;
         endcase
      end
   end

   assign alu_a    = r_hi;
   assign alu_b    = r_lo[0] ? r_mc : '0;
   assign alu_c_in = 1'b0;
   assign done     = r_done;
   assign result   = r_result;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with the real ALU, a scriptable grant driver and an
// arithmetic reference model checked every cycle.
module tb_alu_mul_seq;
   import alu_pkg::*;

   localparam int DATA_W = 8;

   logic          clk;
   logic          rst;
   logic          start;
   logic [7:0]    mcand;
   logic [7:0]    mplier;
   logic          busy;
   logic          done;
   logic [15:0]   result;
   logic          alu_req;
   logic          alu_gnt;
   logic [7:0]    alu_a;
   logic [7:0]    alu_b;
   logic [3:0]    alu_op;
   logic          alu_c_in;
   logic [7:0]    alu_out;
   logic          alu_c;

   int n_checks = 0;
   int n_fail   = 0;

   alu_mul_seq #(.DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mcand    (mcand),
      .mplier   (mplier),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .alu_req  (alu_req),
      .alu_gnt  (alu_gnt),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_op   (alu_op),
      .alu_c_in (alu_c_in),
      .alu_out  (alu_out),
      .alu_c    (alu_c)
   );

   alu #(.DATA_W(DATA_W)) u_alu (
      .i_op   (alu_op),
      .i_a    (alu_a),
      .i_b    (alu_b),
      .i_c_in (alu_c_in),
      .o_out  (alu_out),
      .o_c    (alu_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grant driver: bit n of stall_mask withholds the grant on the n-th RUN cycle.
   logic [31:0] stall_mask = '0;
   int          run_cyc    = 0;
   always @(posedge clk) run_cyc <= alu_req ? run_cyc + 1 : 0;
   assign alu_gnt = ~stall_mask[run_cyc[4:0]];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // Reference model: k = granted steps taken so far; k == DATA_W means the DONE cycle.
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   int          m_steps = 0;
   logic [7:0]  m_mc = '0;
   logic [7:0]  m_mp = '0;
   logic [15:0] m_result = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy   <= 1'b0;
         m_done   <= 1'b0;
         m_steps  <= 0;
         m_result <= '0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy  <= 1'b1;
               m_steps <= 0;
               m_mc    <= mcand;
               m_mp    <= mplier;
            end
         end else if (m_steps < DATA_W) begin
            if (alu_gnt) m_steps <= m_steps + 1;
         end else begin
            m_busy   <= 1'b0;
            m_done   <= 1'b1;
            m_result <= 16'(m_mc) * 16'(m_mp);
         end
      end
   end

   // After k steps hi:lo = (mc * (mp mod 2^k)) << (DATA_W-k) | (mp >> k).
   logic        cmp_en = 1'b0;
   logic        e_run;
   logic [31:0] e_hl;
   logic [7:0]  e_b;
   always @(negedge clk) begin
      if (!rst && cmp_en) begin
         e_run = m_busy && (m_steps < DATA_W);
         chk("busy", int'(busy), int'(m_busy));
         chk("done", int'(done), int'(m_done));
         chk("result", int'(result), int'(m_result));
         chk("alu_req", int'(alu_req), int'(e_run));
         chk("alu_op", int'(alu_op), e_run ? int'(ALU_ADD) : int'(ALU_LD));
         chk("alu_c_in", int'(alu_c_in), 0);
         if (e_run) begin
            e_hl = ((32'(m_mc) * (32'(m_mp) & ((32'd1 << m_steps) - 32'd1)))
                    << (DATA_W - m_steps)) | (32'(m_mp) >> m_steps);
            e_b  = m_mp[m_steps[2:0]] ? m_mc : 8'd0;
            chk("alu_a", int'(alu_a), int'(e_hl[15:8]));
            chk("alu_b", int'(alu_b), int'(e_b));
         end
      end
   end

   int c_cnt   = 0;
   int bnz_cnt = 0;
   always @(negedge clk) begin
      if (alu_req && alu_gnt && alu_c) c_cnt <= c_cnt + 1;
      if (alu_req && (alu_b != 8'd0)) bnz_cnt <= bnz_cnt + 1;
   end

   task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [31:0] mask,
                          input bit poke, input logic [15:0] exp_r, input int exp_lat,
                          input string nm);
      int lat;
      bit got;
      stall_mask = mask;
      @(posedge clk); #1;
      start  = 1'b1;
      mcand  = a;
      mplier = b;
      @(posedge clk); #1;
      start  = 1'b0;
      mcand  = ~a;
      mplier = ~b;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 60) begin
         if (poke && lat == 3) begin
            start  = 1'b1;
            mcand  = 8'd99;
            mplier = 8'd77;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
         if (done) got = 1'b1;
      end
      start = 1'b0;
      chk({nm, "_latency"}, got ? lat : -1, exp_lat);
      chk({nm, "_result"}, int'(result), int'(exp_r));
   endtask

   int c0;
   int b0;

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      mcand  = '0;
      mplier = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_req", int'(alu_req), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_alu_a", int'(alu_a), 0);
      chk("rst_alu_b", int'(alu_b), 0);
      chk("rst_alu_op", int'(alu_op), 0);
      @(posedge clk); #1;
      rst    = 1'b0;
      cmp_en = 1'b1;

      run_mul(8'd13, 8'd11, 32'h0, 1'b0, 16'h008F, 9, "m13x11");

      c0 = c_cnt;
      run_mul(8'd255, 8'd255, 32'h0, 1'b0, 16'hFE01, 9, "m255x255");
      chk("carry_seen", int'(c_cnt > c0), 1);

      run_mul(8'd0, 8'd200, 32'h0, 1'b0, 16'h0000, 9, "m0x200");
      b0 = bnz_cnt;
      run_mul(8'd200, 8'd0, 32'h0, 1'b0, 16'h0000, 9, "m200x0");
      chk("alu_b_zero", bnz_cnt - b0, 0);

      run_mul(8'd37, 8'd91, 32'h0000_0092, 1'b0, 16'h0D27, 12, "m37x91_stall");

      run_mul(8'd21, 8'd5, 32'h0, 1'b1, 16'h0069, 9, "m21x5_poke");
      run_mul(8'd3, 8'd4, 32'h0, 1'b0, 16'h000C, 9, "m3x4_after");

      stall_mask = '0;
      @(posedge clk); #1;
      start  = 1'b1;
      mcand  = 8'd37;
      mplier = 8'd91;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_req", int'(alu_req), 0);
      chk("mid_rst_result", int'(result), 0);
      chk("mid_rst_alu_a", int'(alu_a), 0);
      chk("mid_rst_alu_b", int'(alu_b), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req", int'(alu_req), 0);

      run_mul(8'd6, 8'd7, 32'h0, 1'b0, 16'h002A, 9, "m6x7");

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
